// File: rtl/lsu_pkg.sv
// Shared state encodings, scheduler stage codes and counter widths for the
// load/store unit family.
package lsu_pkg;

  typedef enum logic [1:0] {
    LSU_IDLE       = 2'b00,
    LSU_REQUESTING = 2'b01,
    LSU_WAITING    = 2'b10,
    LSU_DONE       = 2'b11
  } lsu_state_e;

  localparam logic [2:0] CORE_REQUEST = 3'b011;
  localparam logic [2:0] CORE_UPDATE  = 3'b110;

  localparam int STALL_W = 16;

endpackage

// File: rtl/lsu_addr_gen.sv
// Combinational effective-address generator: base, optionally plus a
// sign-extended immediate, resized to the memory address width.
module lsu_addr_gen #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int OFFS_W = 4
) (
  input  logic [DATA_W-1:0] i_base,
  input  logic [OFFS_W-1:0] i_offset,
  input  logic              i_offset_en,
  output logic [ADDR_W-1:0] o_addr
);

  logic [DATA_W-1:0] w_offset_sext;
  logic [DATA_W-1:0] w_sum;

  // The sum wraps in the operand width first, then is truncated or zero-extended.
  assign w_offset_sext = DATA_W'($signed(i_offset));
  assign w_sum         = i_offset_en ? (i_base + w_offset_sext) : i_base;
  assign o_addr        = ADDR_W'(w_sum);

endmodule

// File: rtl/lsu_param.sv
// Per-thread load/store unit: issues one LDR/STR with a held valid/ready
// handshake, with optional request timeout and a saturating stall counter.
module lsu_param
  import lsu_pkg::*;
#(
  parameter int         DATA_W     = 8,
  parameter int         ADDR_W     = 8,
  parameter int         OFFS_W     = 4,
  parameter int         TIMEOUT    = 64,
  parameter logic [2:0] ST_REQUEST = CORE_REQUEST,
  parameter logic [2:0] ST_UPDATE  = CORE_UPDATE
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic [2:0]         core_state,
  input  logic               decoded_mem_read_enable,
  input  logic               decoded_mem_write_enable,
  input  logic               decoded_offset_enable,
  input  logic [OFFS_W-1:0]  decoded_offset,
  input  logic [DATA_W-1:0]  rs,
  input  logic [DATA_W-1:0]  rt,
  input  logic               mem_read_ready,
  input  logic               mem_write_ready,
  input  logic [DATA_W-1:0]  mem_read_data,
  output logic [DATA_W-1:0]  lsu_out,
  output logic [1:0]         lsu_state,
  output logic               lsu_error,
  output logic [STALL_W-1:0] stall_cycles,
  output logic               mem_read_valid,
  output logic               mem_write_valid,
  output logic [ADDR_W-1:0]  mem_read_address,
  output logic [ADDR_W-1:0]  mem_write_address,
  output logic [DATA_W-1:0]  mem_write_data
);

  localparam int TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  lsu_state_e         r_state;
  lsu_state_e         w_state_nxt;
  logic [DATA_W-1:0]  r_out;
  logic               r_error;
  logic [STALL_W-1:0] r_stall;
  logic [TO_W-1:0]    r_to_cnt;
  logic               r_read_valid;
  logic               r_write_valid;
  logic [ADDR_W-1:0]  r_read_addr;
  logic [ADDR_W-1:0]  r_write_addr;
  logic [DATA_W-1:0]  r_write_data;

  logic [ADDR_W-1:0]  w_addr;
  logic               w_issue;
  logic               w_rd_acc;
  logic               w_wr_acc;
  logic               w_accept;
  logic               w_timeout;

  lsu_addr_gen #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .OFFS_W (OFFS_W)
  ) u_addr_gen (
    .i_base      (rs),
    .i_offset    (decoded_offset),
    .i_offset_en (decoded_offset_enable),
    .o_addr      (w_addr)
  );

  // Valids are only ever high in REQUESTING, so acceptance needs no state term.
  assign w_issue   = (r_state == LSU_IDLE) && (core_state == ST_REQUEST) &&
                     (decoded_mem_read_enable || decoded_mem_write_enable);
  assign w_rd_acc  = r_read_valid  && mem_read_ready;
  assign w_wr_acc  = r_write_valid && mem_write_ready;
  assign w_accept  = w_rd_acc || w_wr_acc;
  assign w_timeout = (TIMEOUT > 0) && (r_state == LSU_REQUESTING) && !w_accept &&
                     (r_to_cnt == TO_W'(TIMEOUT - 1));

  always_comb begin
    // NOTE: defaulting every always_comb output first means no path leaves it unassigned, so no latch is inferred.
    w_state_nxt = r_state;
    unique case (r_state)
      LSU_IDLE:       if (w_issue)                  w_state_nxt = LSU_REQUESTING;
      LSU_REQUESTING: if (w_accept || w_timeout)    w_state_nxt = LSU_WAITING;
      LSU_WAITING:    if (core_state == ST_UPDATE)  w_state_nxt = LSU_DONE;
      LSU_DONE:       if (core_state != ST_UPDATE)  w_state_nxt = LSU_IDLE;
      default:                                      w_state_nxt = LSU_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values regardless of statement order.
    if (reset)       r_state <= LSU_IDLE;
    else if (enable) r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_out         <= '0;
      r_error       <= 1'b0;
      r_stall       <= '0;
      r_to_cnt      <= '0;
      r_read_valid  <= 1'b0;
      r_write_valid <= 1'b0;
      r_read_addr   <= '0;
      r_write_addr  <= '0;
      r_write_data  <= '0;
    end else if (enable) begin
      if (w_issue) begin
        r_error  <= 1'b0;
        r_stall  <= '0;
        r_to_cnt <= '0;
        // Read wins when both are decoded.
        if (decoded_mem_read_enable) begin
          r_read_valid <= 1'b1;
          r_read_addr  <= w_addr;
        end else begin
          r_write_valid <= 1'b1;
          r_write_addr  <= w_addr;
          r_write_data  <= rt;
        end
      end else if (r_state == LSU_REQUESTING) begin
        if (r_stall != '1) r_stall <= r_stall + STALL_W'(1);
        r_to_cnt <= r_to_cnt + TO_W'(1);
        if (w_rd_acc) begin
          r_out        <= mem_read_data;
          r_read_valid <= 1'b0;
        end
        if (w_wr_acc) r_write_valid <= 1'b0;
        if (w_timeout) begin
          r_read_valid  <= 1'b0;
          r_write_valid <= 1'b0;
          r_error       <= 1'b1;
        end
      end
    end
  end

  assign lsu_out           = r_out;
  assign lsu_state         = r_state;
  assign lsu_error         = r_error;
  assign stall_cycles      = r_stall;
  assign mem_read_valid    = r_read_valid;
  assign mem_write_valid   = r_write_valid;
  assign mem_read_address  = r_read_addr;
  assign mem_write_address = r_write_addr;
  assign mem_write_data    = r_write_data;

endmodule

// File: tb/tb_lsu_param.sv
// Directed bench for lsu_param: an address table plus hand sequences for
// handshake, timeout (separate TIMEOUT=4 instance), hold and reset cases.
module tb_lsu_param;

  localparam logic [2:0] C_REQ = 3'b011;
  localparam logic [2:0] C_UPD = 3'b110;
  localparam logic [2:0] C_OTH = 3'b000;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [2:0]  core_state;
  logic        rd_en, wr_en, off_en;
  logic [3:0]  offset;
  logic [7:0]  rs, rt;
  logic        rd_rdy, wr_rdy;
  logic [7:0]  rd_data;

  logic [7:0]  lsu_out, t_lsu_out;
  logic [1:0]  lsu_state, t_lsu_state;
  logic        lsu_error, t_lsu_error;
  logic [15:0] stall_cycles, t_stall_cycles;
  logic        rvalid, wvalid, t_rvalid, t_wvalid;
  logic [7:0]  raddr, waddr, wdata, t_raddr, t_waddr, t_wdata;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  lsu_param dut (
    .clk(clk), .reset(reset), .enable(enable), .core_state(core_state),
    .decoded_mem_read_enable(rd_en), .decoded_mem_write_enable(wr_en),
    .decoded_offset_enable(off_en), .decoded_offset(offset),
    .rs(rs), .rt(rt), .mem_read_ready(rd_rdy), .mem_write_ready(wr_rdy),
    .mem_read_data(rd_data), .lsu_out(lsu_out), .lsu_state(lsu_state),
    .lsu_error(lsu_error), .stall_cycles(stall_cycles),
    .mem_read_valid(rvalid), .mem_write_valid(wvalid),
    .mem_read_address(raddr), .mem_write_address(waddr), .mem_write_data(wdata)
  );

  lsu_param #(.TIMEOUT(4)) dut_to (
    .clk(clk), .reset(reset), .enable(enable), .core_state(core_state),
    .decoded_mem_read_enable(rd_en), .decoded_mem_write_enable(wr_en),
    .decoded_offset_enable(off_en), .decoded_offset(offset),
    .rs(rs), .rt(rt), .mem_read_ready(rd_rdy), .mem_write_ready(wr_rdy),
    .mem_read_data(rd_data), .lsu_out(t_lsu_out), .lsu_state(t_lsu_state),
    .lsu_error(t_lsu_error), .stall_cycles(t_stall_cycles),
    .mem_read_valid(t_rvalid), .mem_write_valid(t_wvalid),
    .mem_read_address(t_raddr), .mem_write_address(t_waddr), .mem_write_data(t_wdata)
  );

  typedef struct {
    logic       wr;
    logic [7:0] rs;
    logic [3:0] off;
    logic       oen;
    logic [7:0] exp_addr;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled there too.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; enable = 1'b1; core_state = C_OTH;
    rd_en = 1'b0; wr_en = 1'b0; off_en = 1'b0; offset = 4'h0;
    rs = 8'h00; rt = 8'h00; rd_rdy = 1'b0; wr_rdy = 1'b0; rd_data = 8'h00;
    step();
    reset = 1'b0;
  endtask

  task automatic issue(input logic rd_i, input logic wr_i, input logic [7:0] rs_i,
                       input logic [7:0] rt_i, input logic [3:0] off_i, input logic oen_i);
    rd_en = rd_i; wr_en = wr_i; rs = rs_i; rt = rt_i; offset = off_i; off_en = oen_i;
    core_state = C_REQ;
    step();
    core_state = C_OTH; rd_en = 1'b0; wr_en = 1'b0;
  endtask

  task automatic finish_op();
    rd_rdy = 1'b0; wr_rdy = 1'b0;
    core_state = C_UPD; step();
    core_state = C_OTH; step();
  endtask

  initial begin
    vecs[0] = '{1'b0, 8'h20, 4'h0, 1'b0, 8'h20};
    vecs[1] = '{1'b1, 8'h10, 4'hE, 1'b1, 8'h0E};
    vecs[2] = '{1'b0, 8'hFE, 4'h3, 1'b1, 8'h01};
    vecs[3] = '{1'b1, 8'h7F, 4'h1, 1'b1, 8'h80};
    vecs[4] = '{1'b0, 8'h05, 4'h8, 1'b1, 8'hFD};
    vecs[5] = '{1'b1, 8'hFE, 4'h3, 1'b0, 8'hFE};
    vecs[6] = '{1'b0, 8'h00, 4'hF, 1'b1, 8'hFF};
    vecs[7] = '{1'b1, 8'h80, 4'h7, 1'b1, 8'h87};

    // Reset state
    do_reset();
    check("rst_state", 32'(lsu_state), 32'h0);
    check("rst_out", 32'(lsu_out), 32'h0);
    check("rst_valids", 32'({rvalid, wvalid}), 32'h0);
    check("rst_stall", 32'(stall_cycles), 32'h0);
    check("rst_err", 32'(lsu_error), 32'h0);

    // Address generation table
    for (int i = 0; i < 8; i++) begin
      do_reset();
      issue(!vecs[i].wr, vecs[i].wr, vecs[i].rs, 8'h5A, vecs[i].off, vecs[i].oen);
      check($sformatf("vec%0d_state", i), 32'(lsu_state), 32'h1);
      check($sformatf("vec%0d_valids", i), 32'({rvalid, wvalid}), vecs[i].wr ? 32'h1 : 32'h2);
      check($sformatf("vec%0d_addr", i), vecs[i].wr ? 32'(waddr) : 32'(raddr), 32'(vecs[i].exp_addr));
    end

    // LDR, accepted one cycle after valid
    do_reset();
    issue(1'b1, 1'b0, 8'h20, 8'h00, 4'h0, 1'b0);
    check("ldr_req_state", 32'(lsu_state), 32'h1);
    check("ldr_addr", 32'(raddr), 32'h20);
    rd_rdy = 1'b1; rd_data = 8'hA5;
    step();
    rd_rdy = 1'b0;
    check("ldr_wait_state", 32'(lsu_state), 32'h2);
    check("ldr_out", 32'(lsu_out), 32'hA5);
    check("ldr_stall", 32'(stall_cycles), 32'h1);
    check("ldr_valid_drop", 32'(rvalid), 32'h0);
    core_state = C_UPD; step();
    check("ldr_done_state", 32'(lsu_state), 32'h3);
    core_state = C_OTH; step();
    check("ldr_idle_state", 32'(lsu_state), 32'h0);
    check("ldr_stall_persist", 32'(stall_cycles), 32'h1);
    check("ldr_err", 32'(lsu_error), 32'h0);

    // STR with offset -2, ready withheld 5 cycles
    do_reset();
    issue(1'b0, 1'b1, 8'h10, 8'h3C, 4'hE, 1'b1);
    check("str_valid_c0", 32'(wvalid), 32'h1);
    for (int i = 1; i < 6; i++) begin
      step();
      check($sformatf("str_valid_c%0d", i), 32'(wvalid), 32'h1);
      check($sformatf("str_addr_c%0d", i), 32'(waddr), 32'h0E);
    end
    wr_rdy = 1'b1; rd_rdy = 1'b1;
    step();
    wr_rdy = 1'b0; rd_rdy = 1'b0;
    check("str_valid_drop", 32'(wvalid), 32'h0);
    check("str_no_read", 32'(rvalid), 32'h0);
    check("str_data", 32'(wdata), 32'h3C);
    check("str_stall", 32'(stall_cycles), 32'h6);
    check("str_state", 32'(lsu_state), 32'h2);

    // Timeout (TIMEOUT=4 instance): preload lsu_out, then ready never comes
    do_reset();
    issue(1'b1, 1'b0, 8'h40, 8'h00, 4'h0, 1'b0);
    rd_rdy = 1'b1; rd_data = 8'h5A;
    step();
    finish_op();
    check("to_preload", 32'(t_lsu_out), 32'h5A);
    rd_data = 8'h99;
    issue(1'b1, 1'b0, 8'h44, 8'h00, 4'h0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("to_valid_c%0d", i), 32'(t_rvalid), 32'h1);
      step();
    end
    check("to_valid_drop", 32'(t_rvalid), 32'h0);
    check("to_err", 32'(t_lsu_error), 32'h1);
    check("to_state", 32'(t_lsu_state), 32'h2);
    check("to_out_kept", 32'(t_lsu_out), 32'h5A);
    check("to_stall", 32'(t_stall_cycles), 32'h4);
    check("to_main_still_req", 32'(lsu_state), 32'h1);
    finish_op();
    check("to_err_persist", 32'(t_lsu_error), 32'h1);

    // New request clears error; ready lands on the would-be timeout edge
    issue(1'b1, 1'b0, 8'h48, 8'h00, 4'h0, 1'b0);
    check("to_err_clear", 32'(t_lsu_error), 32'h0);
    check("to_stall_clear", 32'(t_stall_cycles), 32'h0);
    step(); step(); step();
    check("tr_still_valid", 32'(t_rvalid), 32'h1);
    rd_rdy = 1'b1; rd_data = 8'hC3;
    step();
    rd_rdy = 1'b0;
    check("tr_out", 32'(t_lsu_out), 32'hC3);
    check("tr_err", 32'(t_lsu_error), 32'h0);
    check("tr_state", 32'(t_lsu_state), 32'h2);
    check("tr_stall", 32'(t_stall_cycles), 32'h4);

    // Read and write decoded together
    do_reset();
    issue(1'b1, 1'b1, 8'h22, 8'h11, 4'h0, 1'b0);
    check("both_valids", 32'({rvalid, wvalid}), 32'h2);
    check("both_addr", 32'(raddr), 32'h22);

    // enable low holds everything, then reset mid-REQUESTING
    do_reset();
    issue(1'b1, 1'b0, 8'h50, 8'h00, 4'h0, 1'b0);
    rd_rdy = 1'b1; rd_data = 8'h77;
    step();
    finish_op();
    check("hold_preload", 32'(lsu_out), 32'h77);
    issue(1'b1, 1'b0, 8'h33, 8'h00, 4'h0, 1'b0);
    enable = 1'b0; rd_rdy = 1'b1; rd_data = 8'hEE;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("hold_valid_c%0d", i), 32'(rvalid), 32'h1);
      check($sformatf("hold_addr_c%0d", i), 32'(raddr), 32'h33);
      check($sformatf("hold_state_c%0d", i), 32'(lsu_state), 32'h1);
    end
    check("hold_stall", 32'(stall_cycles), 32'h0);
    check("hold_out", 32'(lsu_out), 32'h77);
    enable = 1'b1; rd_rdy = 1'b0;
    step();
    check("hold_resume_stall", 32'(stall_cycles), 32'h1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("midrst_valid", 32'(rvalid), 32'h0);
    check("midrst_state", 32'(lsu_state), 32'h0);
    check("midrst_out", 32'(lsu_out), 32'h0);
    check("midrst_stall", 32'(stall_cycles), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/lsu_param.md
Name: lsu_param

Overview:
- Parametrised next-generation load/store unit; one instance per thread inside a core.
- Issues LDR/STR requests to the memory controller with a true valid/ready handshake: valid is held until it is accepted.
- Adds configurable data/address width, a base+offset address mode, a bounded request timeout with an error flag, and a stall counter for performance monitoring.
- Reports a 2-bit state to the scheduler, with the same encoding as the existing LSU, so it drops into the current core.

Parameters:
- DATA_W, 8, width of register operands and memory data.
- ADDR_W, 8, width of memory addresses.
- OFFS_W, 4, width of the signed immediate offset.
- TIMEOUT, 64, max cycles in REQUESTING before abort; 0 disables the timeout.
- ST_REQUEST, 3'b011, core_state encoding of the REQUEST stage.
- ST_UPDATE, 3'b110, core_state encoding of the UPDATE stage.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- enable  in  1  thread active; when low, all registers hold
- core_state  in  3  scheduler pipeline stage
- decoded_mem_read_enable  in  1  LDR
- decoded_mem_write_enable  in  1  STR
- decoded_offset_enable  in  1  address = rs + sign-extended offset; otherwise rs
- decoded_offset  in  OFFS_W  signed immediate offset
- rs  in  DATA_W  address base
- rt  in  DATA_W  store data
- mem_read_ready  in  1  read accepted; mem_read_data valid in the same cycle
- mem_write_ready  in  1  write accepted
- mem_read_data  in  DATA_W  load data
- lsu_out  out  DATA_W  load result
- lsu_state  out  2  00 IDLE, 01 REQUESTING, 10 WAITING, 11 DONE
- lsu_error  out  1  last operation timed out
- stall_cycles  out  16  cycles spent in REQUESTING by the last operation (saturating)
- mem_read_valid  out  1  read request
- mem_write_valid  out  1  write request
- mem_read_address  out  ADDR_W  read address
- mem_write_address  out  ADDR_W  write address
- mem_write_data  out  DATA_W  write data

Behaviour:
- Reset: on the clk edge with reset=1, all outputs and internal counters go to 0 and state goes to IDLE. This applies mid-operation too: any asserted valid drops on that edge.
- Register hold: with enable=0 and reset=0, every register holds, including an asserted valid.
- Address computation: {rs + sext(decoded_offset)} truncated or zero-extended to ADDR_W; wrap-around modulo 2^ADDR_W. Without offset mode: rs resized to ADDR_W.
- IDLE: when core_state==ST_REQUEST and a read or write is decoded, the following happens on the next edge:
  - Latch the address (and rt for STR) into the request registers.
  - Assert the matching valid.
  - Clear lsu_error, stall_cycles and the timeout counter.
  - Go to REQUESTING.
  - If both read and write are decoded, the read wins and no write is issued.
  - With neither decoded, remain in IDLE.
- REQUESTING: valid, address and data are held stable until accepted.
  - Read accepted (mem_read_valid && mem_read_ready at an edge): lsu_out <= mem_read_data, valid <= 0, go to WAITING.
  - Write accepted (mem_write_valid && mem_write_ready): valid <= 0, go to WAITING.
  - Every edge in REQUESTING increments stall_cycles, saturating at 16'hFFFF. The accepting edge also counts, so a same-cycle accept gives stall_cycles=1.
  - Timeout: if TIMEOUT>0 and the counter reaches TIMEOUT-1 without acceptance, the next edge drops valid, sets lsu_error=1, leaves lsu_out unchanged and goes to WAITING.
  - Ready and timeout on the same edge: acceptance wins; lsu_error stays 0.
  - A ready on the non-requested channel is ignored.
- WAITING: go to DONE on the first edge where core_state==ST_UPDATE.
- DONE: go to IDLE on the first edge where core_state!=ST_UPDATE. lsu_error and stall_cycles persist until the next request starts.
- Latency: minimum request to WAITING is 2 edges (issue edge, then accept edge).
- No back-to-back issue: a request can only start from IDLE.

Decomposition:
- Package lsu_pkg holds:
  - The lsu_state localparams (IDLE, REQUESTING, WAITING, DONE).
  - The core-stage constants REQUEST and UPDATE.
  - The stall counter width, 16.
- One natural sub-module: lsu_addr_gen, a combinational base+offset adder with sign extension and width adaptation, reusable by a future vector LSU.

Test Plan:
- LDR, rs=8'h20, offset mode off, mem_read_ready=1 one cycle after valid, data 8'hA5 -> mem_read_address=8'h20; lsu_out=8'hA5; stall_cycles=1; state sequence 01, 10, 11 (at ST_UPDATE), 00.
- STR, rs=8'h10, rt=8'h3C, offset=-2 (4'hE) with offset mode on, ready withheld 5 cycles -> mem_write_address=8'h0E, data 8'h3C; valid high for exactly 6 cycles; stall_cycles=6.
- Address wrap: rs=8'hFE, offset=+3 -> address 8'h01.
- TIMEOUT=4, ready never asserted -> valid drops after 4 cycles; lsu_error=1; state WAITING; lsu_out unchanged. A new request clears lsu_error.
- Ready asserted on the same cycle the timeout would fire -> data captured and lsu_error=0. Separately, read and write decoded together -> only mem_read_valid asserts.
- enable=0 held 3 cycles during REQUESTING -> valid and address are held; then reset=1 mid-REQUESTING -> next edge gives valid=0, state 00, lsu_out=0.
